// File: rtl/flex_counter_pkg.sv
// Shared types for the programmable counter bank: per-channel counting mode
// and a decoder that folds the reserved encoding onto wrap behaviour.
package flex_counter_pkg;

    typedef enum logic [1:0] {
        CM_WRAP    = 2'b00,
        CM_SAT     = 2'b01,
        CM_ONESHOT = 2'b10
    } cnt_mode_t;

    // 2'b11 is reserved and must behave exactly like wrap
    function automatic cnt_mode_t decode_mode(input logic [1:0] raw);
        cnt_mode_t m;
        case (raw)
            2'b01:   m = CM_SAT;
            2'b10:   m = CM_ONESHOT;
            default: m = CM_WRAP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: count/pulse/done state, rollover detection and the
// combinational rollover event used to drive the next channel in a cascade.
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [1:0]              mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    input  logic                    cascade_in,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_pulse,
    output logic                    done,
    output logic                    evt
);

    logic [NUM_CNT_BITS-1:0] count_reg, count_next;
    logic                    pulse_reg, pulse_next;
    logic                    done_reg, done_next;
    logic                    adv;
    logic                    at_term;

    // >= rather than == so a lowered terminal value still rolls on the next advance
    assign at_term = (count_reg >= rollover_val);
    assign adv     = count_enable & ~done_reg & cascade_in;
    assign evt     = adv & at_term;

    always_comb begin
        count_next = count_reg;
        pulse_next = 1'b0;
        done_next  = done_reg;
        if (clear) begin
            count_next = '0;
            done_next  = 1'b0;
        end else if (adv) begin
            if (at_term) begin
                case (decode_mode(mode))
                    CM_SAT: begin
                        count_next = count_reg;
                    end
                    CM_ONESHOT: begin
                        count_next = '0;
                        pulse_next = 1'b1;
                        done_next  = 1'b1;
                    end
                    default: begin
                        count_next = '0;
                        pulse_next = 1'b1;
                    end
                endcase
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
            pulse_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            pulse_reg <= pulse_next;
            done_reg  <= done_next;
        end
    end

    assign count_out      = count_reg;
    assign rollover_flag  = at_term;
    assign rollover_pulse = pulse_reg;
    assign done           = done_reg;

endmodule

// File: rtl/flex_counter_bank.sv
// Bank of independent or cascaded programmable counters sharing one clock,
// used as the timing and bit-count resource for the packet datapath.
module flex_counter_bank
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 2,
    parameter int CASCADE      = 0
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [2*NUM_CH-1:0]            mode,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              rollover_pulse,
    output logic [NUM_CH-1:0]              done
);

    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] cascade_in;
    logic              unused_evt_tail;

    // the last channel's event has no successor to feed
    assign unused_evt_tail = &{1'b0, evt[NUM_CH-1]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            if (CASCADE == 0 || gi == 0) begin : g_free
                assign cascade_in[gi] = 1'b1;
            end else begin : g_chain
                // purely combinational so a whole chain rolls on the same edge
                assign cascade_in[gi] = evt[gi-1];
            end

            flex_counter_ch #(
                .NUM_CNT_BITS(NUM_CNT_BITS)
            ) u_ch (
                .clk           (clk),
                .n_rst         (n_rst),
                .clear         (clear[gi]),
                .count_enable  (count_enable[gi]),
                .mode          (mode[2*gi +: 2]),
                .rollover_val  (rollover_val[NUM_CNT_BITS*gi +: NUM_CNT_BITS]),
                .cascade_in    (cascade_in[gi]),
                .count_out     (count_out[NUM_CNT_BITS*gi +: NUM_CNT_BITS]),
                .rollover_flag (rollover_flag[gi]),
                .rollover_pulse(rollover_pulse[gi]),
                .done          (done[gi]),
                .evt           (evt[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_flex_counter_bank.sv
// Scoreboard bench: an independent and a cascaded bank share stimulus; a
// rule-level model predicts each edge and a monitor compares after the edge.
module tb_flex_counter_bank;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] clear, count_enable;
    logic [3:0] mode;
    logic [7:0] rollover_val;

    logic [7:0] cnt_a, cnt_b;
    logic [1:0] flag_a, pulse_a, done_a;
    logic [1:0] flag_b, pulse_b, done_b;

    always #5 clk = ~clk;

    flex_counter_bank #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(0)) dut_a (
        .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
        .mode(mode), .rollover_val(rollover_val), .count_out(cnt_a),
        .rollover_flag(flag_a), .rollover_pulse(pulse_a), .done(done_a)
    );

    flex_counter_bank #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1)) dut_b (
        .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
        .mode(mode), .rollover_val(rollover_val), .count_out(cnt_b),
        .rollover_flag(flag_b), .rollover_pulse(pulse_b), .done(done_b)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic [1:0] pulse;
        logic [1:0] done;
        logic [1:0] flag;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   m_cnt [2][2];
    bit   m_done[2][2];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge of bank d (0 independent, 1 cascaded) from the behavioural rules
    task automatic model_edge(input int d, output obs_t o);
        bit evt_prev;
        bit adv, evt;
        int r, m, nc;
        bit nd;
        o = '0;
        evt_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r   = int'(rollover_val[4*i +: 4]);
            m   = int'(mode[2*i +: 2]);
            adv = count_enable[i] && !m_done[d][i] && (d == 0 || i == 0 || evt_prev);
            evt = adv && (m_cnt[d][i] >= r);
            nc  = m_cnt[d][i];
            nd  = m_done[d][i];
            if (clear[i]) begin
                nc = 0;
                nd = 1'b0;
            end else if (evt) begin
                if (m != 1) begin
                    nc = 0;
                    o.pulse[i] = 1'b1;
                    if (m == 2) nd = 1'b1;
                end
            end else if (adv) begin
                nc = m_cnt[d][i] + 1;
            end
            evt_prev = evt;
            m_cnt[d][i]  = nc;
            m_done[d][i] = nd;
            o.cnt[4*i +: 4] = 4'(nc);
            o.done[i] = nd;
            o.flag[i] = (nc >= r);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [1:0] e,
                        input logic [3:0] m, input logic [7:0] r);
        exp_t x;
        @(negedge clk);
        clear = c; count_enable = e; mode = m; rollover_val = r;
        model_edge(0, x.a);
        model_edge(1, x.b);
        sb.push_back(x);
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 2; i++) begin
                m_cnt[d][i]  = 0;
                m_done[d][i] = 1'b0;
            end
    endtask

    task automatic check_reset_state(input string tag);
        logic [1:0] zflag;
        zflag = {rollover_val[7:4] == 4'd0, rollover_val[3:0] == 4'd0};
        chk({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
        chk({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
        chk({tag, "_pulse"}, 32'({pulse_a, pulse_b}), 32'd0);
        chk({tag, "_done"},  32'({done_a, done_b}), 32'd0);
        chk({tag, "_flag_a"}, 32'(flag_a), 32'(zflag));
        chk({tag, "_flag_b"}, 32'(flag_b), 32'(zflag));
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            chk("cnt_a",   32'(cnt_a),   32'(mon_x.a.cnt));
            chk("pulse_a", 32'(pulse_a), 32'(mon_x.a.pulse));
            chk("done_a",  32'(done_a),  32'(mon_x.a.done));
            chk("flag_a",  32'(flag_a),  32'(mon_x.a.flag));
            chk("cnt_b",   32'(cnt_b),   32'(mon_x.b.cnt));
            chk("pulse_b", 32'(pulse_b), 32'(mon_x.b.pulse));
            chk("done_b",  32'(done_b),  32'(mon_x.b.done));
            chk("flag_b",  32'(flag_b),  32'(mon_x.b.flag));
        end
    end

    initial begin
        n_rst = 1'b0;
        clear = '0; count_enable = '0; mode = '0; rollover_val = 8'h55;
        reset_model();
        #12;
        check_reset_state("rst_init");
        @(negedge clk);
        n_rst = 1'b1;

        // wrap, R=5
        repeat (8) step(2'b00, 2'b01, 4'b0000, 8'h05);
        // saturate, R=3
        step(2'b01, 2'b00, 4'b0001, 8'h03);
        repeat (7) step(2'b00, 2'b01, 4'b0001, 8'h03);
        // one-shot on ch1, R=2, then clear and resume
        step(2'b10, 2'b00, 4'b1000, 8'h20);
        repeat (7) step(2'b00, 2'b10, 4'b1000, 8'h20);
        step(2'b10, 2'b10, 4'b1000, 8'h20);
        repeat (3) step(2'b00, 2'b10, 4'b1000, 8'h20);
        // both wrap, R0=3 R1=2: joint rollover in the cascaded bank
        step(2'b11, 2'b00, 4'b0000, 8'h23);
        repeat (16) step(2'b00, 2'b11, 4'b0000, 8'h23);
        // lowered R mid-count, R=0, then clear together with enable
        step(2'b11, 2'b00, 4'b0000, 8'h09);
        repeat (7) step(2'b00, 2'b01, 4'b0000, 8'h09);
        step(2'b00, 2'b01, 4'b0000, 8'h04);
        repeat (4) step(2'b00, 2'b01, 4'b0000, 8'h00);
        step(2'b01, 2'b01, 4'b0000, 8'h00);
        step(2'b00, 2'b00, 4'b0000, 8'h00);
        // reserved mode behaves as wrap
        step(2'b11, 2'b00, 4'b1111, 8'h22);
        repeat (6) step(2'b00, 2'b11, 4'b1111, 8'h22);

        // async reset mid-count with a done channel elsewhere
        step(2'b11, 2'b00, 4'b1000, 8'h19);
        repeat (6) step(2'b00, 2'b11, 4'b1000, 8'h19);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1 check_reset_state("rst_async");
        reset_model();
        clear = '0; count_enable = '0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) step(2'b00, 2'b11, 4'b0000, 8'h19);

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            logic [1:0] c, e;
            logic [3:0] m;
            logic [7:0] r;
            c = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            e = 2'($urandom);
            m = (k % 40 == 0) ? 4'($urandom) : mode;
            r = (k % 25 == 0) ? 8'($urandom_range(0, 255) & 8'h77) : rollover_val;
            step(c, e, m, r);
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
